// File: rtl/register_file_bank.sv
// register_file_bank: 2R/2W register file with per-register busy scoreboard
// Ports: clk/reset (sync, active-high); srcRegister1/2 -> readData1/2, readBusy1/2;
// writeEnable1/2, desRegister1/2, writeData1/2 (port 2 wins on collision);
// reserveEnable/reserveRegister -> reserveStall; busyCount = popcount of busy.
// Optional macro REGFILE_BYPASS_EN forwards same-cycle write data to the read ports.
module register_file_bank #(
  parameter int DATA_WIDTH = 32,
  parameter int REG_NUM    = 32,
  parameter int ADDR_WIDTH = 5
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [ADDR_WIDTH-1:0] srcRegister1,
  input  logic [ADDR_WIDTH-1:0] srcRegister2,
  output logic [DATA_WIDTH-1:0] readData1,
  output logic [DATA_WIDTH-1:0] readData2,
  output logic                  readBusy1,
  output logic                  readBusy2,
  input  logic                  writeEnable1,
  input  logic                  writeEnable2,
  input  logic [ADDR_WIDTH-1:0] desRegister1,
  input  logic [ADDR_WIDTH-1:0] desRegister2,
  input  logic [DATA_WIDTH-1:0] writeData1,
  input  logic [DATA_WIDTH-1:0] writeData2,
  input  logic                  reserveEnable,
  input  logic [ADDR_WIDTH-1:0] reserveRegister,
  output logic                  reserveStall,
  output logic [ADDR_WIDTH:0]   busyCount
);
  logic [DATA_WIDTH-1:0] r_regs [REG_NUM];
  logic [REG_NUM-1:0]    r_busy;
  logic                  w_we1, w_we2, w_hit_res, w_res;
  // x0 is hardwired: writes to it never qualify, so it stays 0 and never busy
  assign w_we1 = writeEnable1 && (desRegister1 != '0);
  assign w_we2 = writeEnable2 && (desRegister2 != '0);
  // a write landing on the reserved register frees it, so the reserve cannot stall
  assign w_hit_res = (w_we1 && desRegister1 == reserveRegister) ||
                     (w_we2 && desRegister2 == reserveRegister);
  assign reserveStall = reserveEnable && r_busy[reserveRegister] && !w_hit_res;
  assign w_res = reserveEnable && (reserveRegister != '0) && !reserveStall;
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < REG_NUM; i++) r_regs[i] <= '0;
      r_busy <= '0;
    end else begin
      if (w_we1) r_regs[desRegister1] <= writeData1;
      if (w_we2) r_regs[desRegister2] <= writeData2;
      if (w_we1) r_busy[desRegister1] <= 1'b0;
      if (w_we2) r_busy[desRegister2] <= 1'b0;
      // last assignment wins: a new producer overrides a same-cycle clear
      if (w_res) r_busy[reserveRegister] <= 1'b1;
    end
  end
  always_comb begin
    busyCount = '0;
    for (int i = 0; i < REG_NUM; i++) busyCount = busyCount + (ADDR_WIDTH+1)'(r_busy[i]);
  end
`ifdef REGFILE_BYPASS_EN
  function automatic logic [DATA_WIDTH-1:0] byp_data(input logic [ADDR_WIDTH-1:0] a);
    return (w_we2 && desRegister2 == a) ? writeData2 :
           (w_we1 && desRegister1 == a) ? writeData1 : r_regs[a];
  endfunction
  function automatic logic byp_busy(input logic [ADDR_WIDTH-1:0] a);
    return ((w_we1 && desRegister1 == a) || (w_we2 && desRegister2 == a)) ?
           (w_res && reserveRegister == a) : r_busy[a];
  endfunction
  assign readData1 = byp_data(srcRegister1);
  assign readData2 = byp_data(srcRegister2);
  assign readBusy1 = byp_busy(srcRegister1);
  assign readBusy2 = byp_busy(srcRegister2);
`else
  assign readData1 = r_regs[srcRegister1];
  assign readData2 = r_regs[srcRegister2];
  assign readBusy1 = r_busy[srcRegister1];
  assign readBusy2 = r_busy[srcRegister2];
`endif
endmodule

// File: tb/tb_register_file_bank.sv
// tb_register_file_bank: randomized + directed check of register_file_bank against a behavioural model
module tb_register_file_bank;
  logic        clk = 1'b0;
  logic        reset;
  logic [4:0]  srcRegister1, srcRegister2, desRegister1, desRegister2, reserveRegister;
  logic [31:0] readData1, readData2, writeData1, writeData2;
  logic        readBusy1, readBusy2, writeEnable1, writeEnable2, reserveEnable, reserveStall;
  logic [5:0]  busyCount;
  int          n_vec = 0;
  int          n_err = 0;
  logic [31:0] m_mem [32];
  bit          m_busy [32];
  always #5 clk = ~clk;
  register_file_bank dut (
    .clk(clk), .reset(reset),
    .srcRegister1(srcRegister1), .srcRegister2(srcRegister2),
    .readData1(readData1), .readData2(readData2),
    .readBusy1(readBusy1), .readBusy2(readBusy2),
    .writeEnable1(writeEnable1), .writeEnable2(writeEnable2),
    .desRegister1(desRegister1), .desRegister2(desRegister2),
    .writeData1(writeData1), .writeData2(writeData2),
    .reserveEnable(reserveEnable), .reserveRegister(reserveRegister),
    .reserveStall(reserveStall), .busyCount(busyCount)
  );
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask
  task automatic model_reset();
    for (int i = 0; i < 32; i++) begin
      m_mem[i] = '0;
      m_busy[i] = 1'b0;
    end
  endtask
  function automatic int model_count();
    int c = 0;
    for (int i = 0; i < 32; i++) c += int'(m_busy[i]);
    return c;
  endfunction
  // what a read of s should show given the stored model and this cycle's writes/reserve
  task automatic exp_rd(input logic [4:0] s, input bit h1, input logic [4:0] d1, input logic [31:0] w1,
                        input bit h2, input logic [4:0] d2, input logic [31:0] w2,
                        input bit re, input logic [4:0] rr, output logic [31:0] x, output bit b);
    x = m_mem[s];
    b = m_busy[s];
`ifdef REGFILE_BYPASS_EN
    if (h2 && d2 == s) x = w2;
    else if (h1 && d1 == s) x = w1;
    if ((h1 && d1 == s) || (h2 && d2 == s)) b = re && rr == s;
`endif
  endtask
  task automatic cyc(input bit rs, input bit e1, input logic [4:0] d1, input logic [31:0] w1,
                     input bit e2, input logic [4:0] d2, input logic [31:0] w2,
                     input bit re, input logic [4:0] rr, input logic [4:0] s1, input logic [4:0] s2);
    logic [31:0] x1, x2;
    bit b1, b2, st, h1, h2;
    @(negedge clk);
    reset = rs; writeEnable1 = e1; desRegister1 = d1; writeData1 = w1;
    writeEnable2 = e2; desRegister2 = d2; writeData2 = w2;
    reserveEnable = re; reserveRegister = rr; srcRegister1 = s1; srcRegister2 = s2;
    h1 = e1 && d1 != 0;
    h2 = e2 && d2 != 0;
    st = re && m_busy[rr] && !((h1 && d1 == rr) || (h2 && d2 == rr));
    exp_rd(s1, h1, d1, w1, h2, d2, w2, re, rr, x1, b1);
    exp_rd(s2, h1, d1, w1, h2, d2, w2, re, rr, x2, b2);
    #2;
    chk("readData1", readData1, x1);
    chk("readData2", readData2, x2);
    chk("readBusy1", 32'(readBusy1), 32'(b1));
    chk("readBusy2", 32'(readBusy2), 32'(b2));
    chk("reserveStall", 32'(reserveStall), 32'(st));
    chk("busyCount", 32'(busyCount), 32'(model_count()));
    @(posedge clk);
    #1;
    if (rs) model_reset();
    else begin
      if (h1) begin m_mem[d1] = w1; m_busy[d1] = 1'b0; end
      if (h2) begin m_mem[d2] = w2; m_busy[d2] = 1'b0; end
      if (re && rr != 0 && !st) m_busy[rr] = 1'b1;
    end
  endtask
  task automatic idle(input logic [4:0] s1, input logic [4:0] s2);
    cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, s1, s2);
  endtask
  task automatic peek(input logic [4:0] s);
    @(negedge clk);
    reset = 0; writeEnable1 = 0; writeEnable2 = 0; reserveEnable = 0; srcRegister1 = s; srcRegister2 = s;
    #2;
  endtask
  initial begin
    logic [31:0] v;
    model_reset();
    reset = 1; writeEnable1 = 0; writeEnable2 = 0; reserveEnable = 0;
    desRegister1 = 0; desRegister2 = 0; writeData1 = 0; writeData2 = 0;
    reserveRegister = 0; srcRegister1 = 0; srcRegister2 = 0;
    @(posedge clk);
    #1;
    peek(0);
    chk("rst_busyCount", 32'(busyCount), 0);
    for (int i = 0; i < 32; i++) idle(5'(i), 5'(31 - i));
    for (int i = 0; i < 32; i++) cyc(0, 1, 5'(i), 32'(i + 1), 0, 0, 0, 0, 0, 5'(i), 5'(i - 1));
    for (int i = 0; i < 32; i++) begin
      peek(5'(i));
      chk("p1_sweep", readData1, i == 0 ? 32'd0 : 32'(i + 1));
    end
    cyc(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 32; i++) cyc(0, 0, 0, 0, 1, 5'(i), 32'(i + 1), 0, 0, 5'(i), 5'(i - 1));
    for (int i = 0; i < 32; i++) begin
      peek(5'(i));
      chk("p2_sweep", readData2, i == 0 ? 32'd0 : 32'(i + 1));
    end
    cyc(0, 1, 5, 32'hAAAA, 1, 5, 32'h5555, 0, 0, 5, 5);
    peek(5);
    chk("x5_collide", readData1, 32'h5555);
    cyc(0, 0, 0, 0, 0, 0, 0, 1, 3, 3, 0);
    cyc(0, 0, 0, 0, 0, 0, 0, 1, 3, 3, 0);
    peek(3);
    chk("x3_busy", 32'(readBusy1), 1);
    chk("x3_count", 32'(busyCount), 1);
    cyc(0, 1, 3, 32'h33, 0, 0, 0, 0, 0, 3, 0);
    cyc(0, 0, 0, 0, 0, 0, 0, 1, 0, 3, 0);
    peek(3);
    chk("x3_freed", 32'(readBusy1), 0);
    chk("x0_count", 32'(busyCount), 0);
    cyc(0, 0, 0, 0, 0, 0, 0, 1, 4, 4, 7);
    cyc(0, 1, 4, 32'h44, 0, 0, 0, 1, 7, 4, 7);
    peek(7);
    chk("swap_count", 32'(busyCount), 1);
    cyc(0, 0, 0, 0, 1, 7, 32'h77, 1, 7, 7, 7);
    peek(7);
    chk("x7_rw_busy", 32'(readBusy1), 1);
    chk("x7_rw_data", readData1, 32'h77);
    cyc(0, 1, 9, 32'h1234, 0, 0, 0, 0, 0, 9, 9);
    cyc(0, 0, 0, 0, 0, 0, 0, 1, 10, 10, 9);
    cyc(1, 1, 11, 32'hDEAD, 0, 0, 0, 1, 12, 10, 11);
    peek(10);
    chk("rst_pend_count", 32'(busyCount), 0);
    chk("rst_pend_busy", 32'(readBusy1), 0);
    chk("rst_over_wr", readData2, 0);
    for (int k = 0; k < 400; k++) begin
      bit narrow = $urandom_range(0, 1) == 1;
      logic [4:0] a [6];
      for (int j = 0; j < 6; j++) a[j] = narrow ? 5'($urandom_range(0, 7)) : 5'($urandom_range(0, 31));
      v = $urandom;
      cyc($urandom_range(0, 39) == 0, $urandom_range(0, 1) == 1, a[0], v,
          $urandom_range(0, 1) == 1, a[1], $urandom,
          $urandom_range(0, 1) == 1, a[2], a[3], a[4]);
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/register_file_bank.md
REGISTER_FILE_BANK -- requirements
Module: register_file_bank

Interface
REQ-001 Parameter DATA_WIDTH, default 32, width of each register and of the read and write data ports.
REQ-002 Parameter REG_NUM, default 32, number of architectural registers; must be a power of two and at least 4.
REQ-003 Parameter ADDR_WIDTH, default 5, register index width; equal to log2(REG_NUM).
REQ-004 Port clk, input, 1, the only clock; all state updates on its rising edge.
REQ-005 Port reset, input, 1, synchronous active-high reset.
REQ-006 Ports srcRegister1 and srcRegister2, input, ADDR_WIDTH, read addresses.
REQ-007 Ports readData1 and readData2, output, DATA_WIDTH, combinational read data.
REQ-008 Ports readBusy1 and readBusy2, output, 1, scoreboard busy flag of the addressed register.
REQ-009 Ports writeEnable1 and writeEnable2, input, 1, write strobes for write ports 1 and 2.
REQ-010 Ports desRegister1 and desRegister2, input, ADDR_WIDTH, write addresses.
REQ-011 Ports writeData1 and writeData2, input, DATA_WIDTH, write data.
REQ-012 Port reserveEnable, input, 1, request to mark reserveRegister busy (pending producer).
REQ-013 Port reserveRegister, input, ADDR_WIDTH, register to reserve.
REQ-014 Port reserveStall, output, 1, reservation rejected this cycle.
REQ-015 Port busyCount, output, ADDR_WIDTH+1, number of registers currently busy.

Function
REQ-016 Writes take effect at the rising clk edge while the strobe is high; read-after-write latency is one cycle.
REQ-017 Register x0 reads zero, is never written, and is never busy; all reads, writes and reservations to x0 are ignored.
REQ-018 Two writes to the same non-zero address in the same cycle: port 2 data is stored.
REQ-019 Reads are asynchronous from the stored array; both read ports are independent and may address the same register.
REQ-020 A write to register r clears busy[r] at the same edge.
REQ-021 Reserve of a non-busy, non-zero register sets busy[r] at the next edge.
REQ-022 Reserve and write to the same register in the same cycle: data is stored and busy[r] ends set (the new producer wins).
REQ-023 reserveStall = reserveEnable AND busy[reserveRegister] AND no write to reserveRegister this cycle; on a stall, the busy array is unchanged.
REQ-024 busyCount equals the population count of busy[]; when one reservation and one clear of different registers occur in the same cycle, busyCount is unchanged.
REQ-025 busyCount never exceeds REG_NUM-1; a clear of a non-busy register does not decrement the count.

Reset
REQ-026 On the rising edge with reset high, all registers are set to 0, busy[] to 0 and busyCount to 0.
REQ-027 Reset overrides any write or reserve presented in the same cycle.
REQ-028 Reset asserted mid-operation discards all pending reservations; after reset, readBusy1, readBusy2 and reserveStall are 0.

Configuration
REQ-029 Macro REGFILE_BYPASS_EN defined: a read of an address being written in the same cycle returns the write data, using port 2 priority, and readBusy for that address reads 0 unless a same-cycle reserve targets it.
REQ-030 Macro REGFILE_BYPASS_EN undefined: reads always return the stored array value and the stored busy bit; no combinational path exists from the write ports to the read outputs.

Verification
REQ-031 Reset, then sweep srcRegister1 and srcRegister2 over 0..31 -> readData 0, readBusy 0 and busyCount 0 for every address.
REQ-032 Write x[i]=i+1 through port 1 for i=0..31 and read one cycle later -> x0 reads 0 and x[i] reads i+1; same sweep through port 2 with the same result.
REQ-033 Same cycle writeEnable1 and writeEnable2 to x5 with data 0xAAAA and 0x5555 -> x5 reads 0x5555 the next cycle.
REQ-034 Reserve x3, then reserve x3 again -> readBusy 1, second reserveStall 1, busyCount 1; write x3 -> busy 0, busyCount 0; reserve x0 -> busyCount stays 0.
REQ-035 Reserve x7 while writing x4 (which is busy) -> busyCount unchanged at 1; reserve and write x7 in the same cycle -> busy[7] 1.
REQ-036 With REGFILE_BYPASS_EN, write x9=0x1234 while reading x9 in the same cycle -> readData 0x1234 before the edge; without the macro, the old value is read; reset during a pending reserve -> busyCount 0.
